// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI mode-0 slave front-end decoding opcode/address/data frames for spi_mem.
// Define SPI_AUTOINC_EN for burst transfers with auto-incrementing address.
module spi_slave_if #(
  parameter int          ADDR_W      = 8,
  parameter int          DATA_W      = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  OP_WR       = 8'h02,
  parameter logic [7:0]  OP_RD       = 8'h03
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              frame_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR_W,
    S_ADDR_R,
    S_WDATA,
    S_RDATA,
    S_IGNORE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_prev;
  logic [2:0]             r_bit_cnt;
  logic [DATA_W-1:0]      r_rx_sr;
  logic [DATA_W-1:0]      r_tx_sr;
  logic                   r_load_pend;

  logic              w_sclk;
  logic              w_mosi;
  logic              w_cs_act;
  logic              w_rise;
  logic              w_fall;
  logic              w_byte_done;
  logic [DATA_W-1:0] w_byte;
  logic              w_bad_op;
  logic              w_cs_abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_act    = ~r_cs_sync[SYNC_STAGES-1];
  // A deselect in the same clk as an SCLK edge discards the edge.
  assign w_rise      = w_cs_act & w_sclk & ~r_sclk_prev;
  assign w_fall      = w_cs_act & ~w_sclk & r_sclk_prev;
  assign w_byte_done = w_rise && (r_bit_cnt == 3'd7);
  assign w_byte      = {r_rx_sr[DATA_W-2:0], w_mosi};
  assign w_bad_op    = (r_state == S_CMD) && w_byte_done &&
                       (w_byte != OP_WR) && (w_byte != OP_RD);
  assign w_cs_abort  = ~w_cs_act && (r_bit_cnt != 3'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (!w_cs_act) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   w_next = S_CMD;
        S_CMD: begin
          if (w_byte_done) begin
            if (w_byte == OP_WR) begin
              w_next = S_ADDR_W;
            end else if (w_byte == OP_RD) begin
              w_next = S_ADDR_R;
            end else begin
              w_next = S_IGNORE;
            end
          end
        end
        S_ADDR_W: if (w_byte_done) w_next = S_WDATA;
        S_ADDR_R: if (w_byte_done) w_next = S_RDATA;
`ifdef SPI_AUTOINC_EN
        S_WDATA:  w_next = S_WDATA;
        S_RDATA:  w_next = S_RDATA;
`else
        S_WDATA:  if (w_byte_done) w_next = S_IGNORE;
        S_RDATA:  if (w_byte_done) w_next = S_IGNORE;
`endif
        S_IGNORE: w_next = S_IGNORE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_prev <= 1'b0;
      r_bit_cnt   <= 3'd0;
      r_rx_sr     <= '0;
      r_tx_sr     <= '0;
      r_load_pend <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= '0;
      frame_err   <= 1'b0;
    end else begin
      r_sclk_prev <= w_sclk;
      mem_wr      <= 1'b0;
      r_load_pend <= 1'b0;
      frame_err   <= w_bad_op | w_cs_abort;
`ifdef SPI_AUTOINC_EN
      // Burst write: advance the address in the clk after the strobe.
      if (mem_wr) begin
        mem_addr <= mem_addr + ADDR_W'(1);
      end
`endif
      if (!w_cs_act) begin
        r_bit_cnt <= 3'd0;
        r_rx_sr   <= '0;
        r_tx_sr   <= '0;
      end else begin
        if (w_rise) begin
          r_rx_sr   <= w_byte;
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
        // The first bit of each byte is already on miso, so its falling edge is skipped.
        if (w_fall && (r_bit_cnt != 3'd0) && (r_state == S_RDATA)) begin
          r_tx_sr <= {r_tx_sr[DATA_W-2:0], 1'b0};
        end
        if (r_load_pend) begin
          r_tx_sr <= mem_dout;
        end
        if (w_byte_done) begin
          case (r_state)
            S_ADDR_W: mem_addr <= ADDR_W'(w_byte);
            S_ADDR_R: begin
              mem_addr    <= ADDR_W'(w_byte);
              r_load_pend <= 1'b1;
            end
            S_WDATA: begin
              mem_din <= w_byte;
              mem_wr  <= 1'b1;
            end
`ifdef SPI_AUTOINC_EN
            S_RDATA: begin
              mem_addr    <= mem_addr + ADDR_W'(1);
              r_load_pend <= 1'b1;
            end
`endif
            default: ;
          endcase
        end
      end
    end
  end

  assign miso = (r_state == S_RDATA) & r_tx_sr[DATA_W-1];
  assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_slave_if.sv
// tb/tb_spi_slave_if.sv - scoreboard bench for spi_slave_if driving directed SPI frames.
module tb_spi_slave_if;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic       mem_wr;
  logic [7:0] mem_addr;
  logic [7:0] mem_din;
  logic [7:0] mem_dout;
  logic       busy;
  logic       frame_err;

  logic [7:0] mem [256];

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    int    kind;
    int    exp_err;
    int    exp_addr;
  } mark_t;

  wr_t   wr_q[$];
  logic  miso_q[$];
  mark_t mk_q[$];

  int checks = 0;
  int errors = 0;

  spi_slave_if dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  assign mem_dout = mem[mem_addr];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
    end else if (mem_wr) begin
      mem[mem_addr] <= mem_din;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: the only process that compares and steps the counters.
  initial begin : monitor
    logic  sclk_prev;
    int    err_cnt;
    wr_t   w;
    logic  b;
    mark_t m;
    sclk_prev = 1'b0;
    err_cnt   = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        err_cnt = 0;
      end else begin
        if (mem_wr === 1'b1) begin
          if (wr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_wr actual=addr %0h data %0h required=no write", mem_addr, mem_din);
          end else begin
            w = wr_q.pop_front();
            chk("wr_addr", 32'(mem_addr), 32'(w.addr));
            chk("wr_data", 32'(mem_din), 32'(w.data));
          end
        end
        if (frame_err === 1'b1) err_cnt++;
        if (sclk && !sclk_prev && !cs_n) begin
          if (miso_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL miso_underflow actual=%0b required=no bit", miso);
          end else begin
            b = miso_q.pop_front();
            chk("miso_bit", 32'(miso), 32'(b));
          end
        end
      end
      sclk_prev = sclk;
      if (mk_q.size() > 0) begin
        m = mk_q.pop_front();
        if (m.kind == 1) begin
          chk("rst_miso", 32'(miso), 0);
          chk("rst_mem_wr", 32'(mem_wr), 0);
          chk("rst_mem_addr", 32'(mem_addr), 0);
          chk("rst_mem_din", 32'(mem_din), 0);
          chk("rst_busy", 32'(busy), 0);
          chk("rst_frame_err", 32'(frame_err), 0);
        end else begin
          chk("frame_err_count", 32'(err_cnt), 32'(m.exp_err));
          chk("busy_after_frame", 32'(busy), 0);
          chk("miso_after_frame", 32'(miso), 0);
          chk("missing_writes", 32'(wr_q.size()), 0);
          chk("unclocked_bits", 32'(miso_q.size()), 0);
          if (m.exp_addr >= 0) chk("hold_mem_addr", 32'(mem_addr), 32'(m.exp_addr));
          err_cnt = 0;
        end
      end
    end
  end

  task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    wr_q.push_back(w);
  endtask

  task automatic push_mark(input int kind, input int exp_err, input int exp_addr);
    mark_t m;
    m.kind     = kind;
    m.exp_err  = exp_err;
    m.exp_addr = exp_addr;
    mk_q.push_back(m);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, input logic [7:0] exp_miso);
    for (int i = 0; i < n; i++) begin
      mosi = b[7-i];
      #40;
      miso_q.push_back(exp_miso[7-i]);
      sclk = 1'b1;
      #80;
      sclk = 1'b0;
      #40;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [7:0] exp_miso);
    send_bits(b, 8, exp_miso);
  endtask

  task automatic start_frame();
    @(negedge clk);
    #2;
    cs_n = 1'b0;
    #160;
  endtask

  task automatic end_frame(input int exp_err, input int exp_addr);
    #80;
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (10) @(negedge clk);
    push_mark(0, exp_err, exp_addr);
    repeat (4) @(negedge clk);
  endtask

  initial begin : stimulus
    rst  = 1'b1;
    sclk = 1'b0;
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (2) @(negedge clk);
    push_mark(1, 0, -1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // write [10]=A5
    push_wr(8'h10, 8'hA5);
    start_frame();
    send_byte(8'h02, 8'h00);
    send_byte(8'h10, 8'h00);
    send_byte(8'hA5, 8'h00);
    end_frame(0, 8'h10);

    // read back [10]
    start_frame();
    send_byte(8'h03, 8'h00);
    send_byte(8'h10, 8'h00);
    send_byte(8'h00, 8'hA5);
    end_frame(0, -1);

    // read reset-pattern location [33] = 33^5A = 69
    start_frame();
    send_byte(8'h03, 8'h00);
    send_byte(8'h33, 8'h00);
    send_byte(8'hFF, 8'h69);
    end_frame(0, -1);

    // partial data byte: no write, one frame_err, address held
    start_frame();
    send_byte(8'h02, 8'h00);
    send_byte(8'h20, 8'h00);
    send_bits(8'hF0, 4, 8'h00);
    end_frame(1, 8'h20);

    // bad opcode then two ignored bytes
    start_frame();
    send_byte(8'h55, 8'h00);
    send_byte(8'hAA, 8'h00);
    send_byte(8'h33, 8'h00);
    end_frame(1, -1);

    // burst write across the address wrap
    push_wr(8'hFF, 8'h11);
`ifdef SPI_AUTOINC_EN
    push_wr(8'h00, 8'h22);
`endif
    start_frame();
    send_byte(8'h02, 8'h00);
    send_byte(8'hFF, 8'h00);
    send_byte(8'h11, 8'h00);
    send_byte(8'h22, 8'h00);
`ifdef SPI_AUTOINC_EN
    end_frame(0, 8'h01);
`else
    end_frame(0, 8'hFF);
`endif

    // reset asserted mid address byte, between clock edges
    start_frame();
    send_byte(8'h02, 8'h00);
    send_bits(8'h44, 4, 8'h00);
    @(negedge clk);
    #6;
    rst = 1'b1;
    push_mark(1, 0, -1);
    #20;
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    push_wr(8'h10, 8'hA5);
    start_frame();
    send_byte(8'h02, 8'h00);
    send_byte(8'h10, 8'h00);
    send_byte(8'hA5, 8'h00);
    end_frame(0, 8'h10);

    repeat (20) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
